// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: sequences ALU, unified memory, PC and register file.
// Latency: R/imm 4 cycles, lw 5, sw 4, beq/bne 3, j 3; outputs are decoded from the current state.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready_i; optional MULTICYCLE_PERF_CNT_EN adds counters.
module multicycle_control #(
   parameter int CNT_WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       i_or_d_o,
   output logic       reg_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] pc_src_o,
   output logic       halted_o,
   output logic [3:0] state_o
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] cycle_count_o,
   output logic [CNT_WIDTH-1:0] instr_count_o
`endif
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_IMM_EXEC  = 4'd10,
      S_IMM_WB    = 4'd11,
      S_JUMP      = 4'd12,
      S_HALT      = 4'd13
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [2:0] ALU_RTYPE = 3'b111;
   localparam logic [2:0] ALU_ADDI  = 3'b100;
   localparam logic [2:0] ALU_LUI   = 3'b001;
   localparam logic [2:0] ALU_ORI   = 3'b010;
   localparam logic [2:0] ALU_ANDI  = 3'b011;
   localparam logic [2:0] ALU_ADD   = 3'b101;
   localparam logic [2:0] ALU_SUB   = 3'b110;

   state_t     state;
   state_t     state_nxt;
   logic [5:0] opc_q;

   // State register; reset forces IDLE so every decoded output drops at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Opcode is latched in DECODE so later steps ignore IR/opcode bus changes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         opc_q <= 6'd0;
      end else if (state == S_DECODE) begin
         opc_q <= opcode_i;
      end
   end

   // Next-state logic: DECODE dispatches on the live opcode, later states on the latched copy.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      state_nxt = S_FETCH;
         S_FETCH:     if (mem_ready_i) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode_i)
               OP_LW, OP_SW:                    state_nxt = S_MEM_ADDR;
               OP_R:                            state_nxt = S_EXECUTE;
               OP_BEQ, OP_BNE:                  state_nxt = S_BRANCH;
               OP_J:                            state_nxt = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_nxt = S_IMM_EXEC;
               default:                         state_nxt = S_HALT;
            endcase
         end
         S_MEM_ADDR:  state_nxt = (opc_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready_i) state_nxt = S_MEM_WB;
         S_MEM_WB:    state_nxt = S_FETCH;
         S_MEM_WRITE: if (mem_ready_i) state_nxt = S_FETCH;
         S_EXECUTE:   state_nxt = S_ALU_WB;
         S_ALU_WB:    state_nxt = S_FETCH;
         S_BRANCH:    state_nxt = S_FETCH;
         S_IMM_EXEC:  state_nxt = S_IMM_WB;
         S_IMM_WB:    state_nxt = S_FETCH;
         S_JUMP:      state_nxt = S_FETCH;
         S_HALT:      state_nxt = S_HALT;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Output decode from state; only FETCH write enables and the branch PC write look at inputs.
   always_comb begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      i_or_d_o     = 1'b0;
      reg_write_o  = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = ALU_ADD;
      pc_src_o     = 2'b00;
      halted_o     = 1'b0;
      state_o      = state;
      case (state)
         S_IDLE: begin
            alu_op_o = 3'b000;
         end
         S_FETCH: begin
            // PC+4 is computed while the instruction is read; both land when memory answers.
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         S_DECODE: begin
            // Speculative branch target into ALUOut.
            alu_src_b_o = 2'b11;
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
         end
         S_MEM_READ: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write_o = 1'b1;
            i_or_d_o    = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_RTYPE;
         end
         S_ALU_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_SUB;
            pc_src_o    = 2'b01;
            pc_write_o  = ((opc_q == OP_BEQ) && zero_i) ||
                          ((opc_q == OP_BNE) && !zero_i);
         end
         S_IMM_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            case (opc_q)
               OP_ADDI: alu_op_o = ALU_ADDI;
               OP_ANDI: alu_op_o = ALU_ANDI;
               OP_ORI:  alu_op_o = ALU_ORI;
               OP_LUI:  alu_op_o = ALU_LUI;
               default: alu_op_o = ALU_ADD;
            endcase
         end
         S_IMM_WB: begin
            reg_write_o = 1'b1;
         end
         S_JUMP: begin
            pc_src_o   = 2'b10;
            pc_write_o = 1'b1;
         end
         S_HALT: begin
            alu_op_o = 3'b000;
            halted_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef MULTICYCLE_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] cycle_cnt_q;
   logic [CNT_WIDTH-1:0] instr_cnt_q;
   logic                 instr_done;

   // An instruction retires on any write-back/terminal step handing control back to FETCH.
   always_comb begin
      instr_done = 1'b0;
      if (state_nxt == S_FETCH) begin
         instr_done = (state == S_MEM_WB)  || (state == S_MEM_WRITE) ||
                      (state == S_ALU_WB)  || (state == S_BRANCH)    ||
                      (state == S_IMM_WB)  || (state == S_JUMP);
      end
   end

   // Free-running wrap-around counters of busy cycles and retired instructions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         if ((state != S_IDLE) && (state != S_HALT)) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
         end
         if (instr_done) begin
            instr_cnt_q <= instr_cnt_q + CNT_ONE;
         end
      end
   end

   assign cycle_count_o = cycle_cnt_q;
   assign instr_count_o = instr_cnt_q;
`else
   // Counters absent; the width parameter is only sanity-checked here.
   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
   end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: scoreboard of per-cycle expected output vectors.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Wait states are inserted explicitly in FETCH, MEM_READ and MEM_WRITE.
module tb_multicycle_control;

   localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEM_ADDR = 4'd3,
                          S_MEM_READ = 4'd4, S_MEM_WB = 4'd5, S_MEM_WRITE = 4'd6, S_EXECUTE = 4'd7,
                          S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_IMM_EXEC = 4'd10, S_IMM_WB = 4'd11,
                          S_JUMP = 4'd12, S_HALT = 4'd13;

   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                          OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                          OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       pc_write_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o;
   logic       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, halted_o;
   logic [1:0] alu_src_b_o, pc_src_o;
   logic [2:0] alu_op_o;
   logic [3:0] state_o;
`ifdef MULTICYCLE_PERF_CNT_EN
   logic [31:0] cycle_count_o, instr_count_o;
`endif

   logic [20:0] dut_vec;
   logic [20:0] exp_q[$];
   logic [5:0]  cap_opc;
   int          tests = 0;
   int          fails = 0;

   multicycle_control #(.CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .mem_read_o(mem_read_o),
      .mem_write_o(mem_write_o), .i_or_d_o(i_or_d_o), .reg_write_o(reg_write_o),
      .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
      .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .pc_src_o(pc_src_o),
      .halted_o(halted_o), .state_o(state_o)
`ifdef MULTICYCLE_PERF_CNT_EN
      , .cycle_count_o(cycle_count_o), .instr_count_o(instr_count_o)
`endif
   );

   always #5 clk = ~clk;

   assign dut_vec = {state_o, pc_write_o, ir_write_o, mem_read_o, mem_write_o, i_or_d_o,
                     reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
                     alu_op_o, pc_src_o, halted_o};

   // Expected output vector for one cycle, straight from the state table.
   function automatic logic [20:0] model(input logic [3:0] st, input logic [5:0] cap,
                                         input logic z, input logic rdy);
      logic pcw, irw, mr, mw, iod, rw, rd, m2r, sa, hlt;
      logic [1:0] sb, ps;
      logic [2:0] op;
      {pcw, irw, mr, mw, iod, rw, rd, m2r, sa, hlt} = '0;
      sb = 2'b00; ps = 2'b00; op = 3'b101;
      case (st)
         S_IDLE:      op = 3'b000;
         S_FETCH:     begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
         S_DECODE:    sb = 2'b11;
         S_MEM_ADDR:  begin sa = 1'b1; sb = 2'b10; end
         S_MEM_READ:  begin mr = 1'b1; iod = 1'b1; end
         S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
         S_MEM_WRITE: begin mw = 1'b1; iod = 1'b1; end
         S_EXECUTE:   begin sa = 1'b1; op = 3'b111; end
         S_ALU_WB:    begin rw = 1'b1; rd = 1'b1; end
         S_BRANCH: begin
            sa = 1'b1; op = 3'b110; ps = 2'b01;
            pcw = ((cap == OP_BEQ) && z) || ((cap == OP_BNE) && !z);
         end
         S_IMM_EXEC: begin
            sa = 1'b1; sb = 2'b10;
            if (cap == OP_ADDI) op = 3'b100;
            else if (cap == OP_ANDI) op = 3'b011;
            else if (cap == OP_ORI) op = 3'b010;
            else if (cap == OP_LUI) op = 3'b001;
         end
         S_IMM_WB:    rw = 1'b1;
         S_JUMP:      begin ps = 2'b10; pcw = 1'b1; end
         S_HALT:      begin op = 3'b000; hlt = 1'b1; end
         default: ;
      endcase
      return {st, pcw, irw, mr, mw, iod, rw, rd, m2r, sa, sb, op, ps, hlt};
   endfunction

   // One cycle: drive inputs at the falling edge, push expectation, sample, compare.
   task automatic step(input string tag, input logic [3:0] st, input logic rdy,
                       input logic z, input logic [5:0] opc);
      logic [20:0] exp_v;
      opcode_i = opc; zero_i = z; mem_ready_i = rdy;
      exp_q.push_back(model(st, cap_opc, z, rdy));
      if (st == S_DECODE) cap_opc = opc;
      #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (dut_vec !== exp_v) begin
         fails++;
         $display("FAIL %s state%0d: got %h expected %h", tag, st, dut_vec, exp_v);
      end
      @(negedge clk);
   endtask

   // Assert reset mid-cycle and require all outputs low without waiting for a clock.
   task automatic assert_reset(input string tag);
      logic [20:0] exp_v;
      reset = 1'b0;
      exp_q.push_back(21'd0);
      #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (dut_vec !== exp_v) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, dut_vec, exp_v);
      end
      @(negedge clk);
      reset = 1'b1;
      cap_opc = 6'd0;
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] ropc();
      return 6'($urandom);
   endfunction

   // One instruction from FETCH to its last step, with fw/mw wait cycles.
   task automatic run_instr(input string tag, input logic [5:0] opc, input int fw,
                            input int mw, input logic z);
      for (int i = 0; i < fw; i++) step(tag, S_FETCH, 1'b0, rbit(), ropc());
      step(tag, S_FETCH, 1'b1, rbit(), ropc());
      step(tag, S_DECODE, rbit(), rbit(), opc);
      case (opc)
         OP_R: begin
            step(tag, S_EXECUTE, rbit(), rbit(), ropc());
            step(tag, S_ALU_WB, rbit(), rbit(), ropc());
         end
         OP_LW: begin
            step(tag, S_MEM_ADDR, rbit(), rbit(), ropc());
            for (int i = 0; i < mw; i++) step(tag, S_MEM_READ, 1'b0, rbit(), ropc());
            step(tag, S_MEM_READ, 1'b1, rbit(), ropc());
            step(tag, S_MEM_WB, rbit(), rbit(), ropc());
         end
         OP_SW: begin
            step(tag, S_MEM_ADDR, rbit(), rbit(), ropc());
            for (int i = 0; i < mw; i++) step(tag, S_MEM_WRITE, 1'b0, rbit(), ropc());
            step(tag, S_MEM_WRITE, 1'b1, rbit(), ropc());
         end
         OP_BEQ, OP_BNE: step(tag, S_BRANCH, rbit(), z, ropc());
         OP_J: step(tag, S_JUMP, rbit(), rbit(), ropc());
         OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
            step(tag, S_IMM_EXEC, rbit(), rbit(), ropc());
            step(tag, S_IMM_WB, rbit(), rbit(), ropc());
         end
         default: step(tag, S_HALT, rbit(), rbit(), ropc());
      endcase
   endtask

   task automatic test_reset();
      logic [20:0] exp_v;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(21'd0);
         #1;
         exp_v = exp_q.pop_front();
         tests++;
         if (dut_vec !== exp_v) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec, exp_v);
         end
         @(negedge clk);
      end
      reset = 1'b1;
      step("idle_after_reset", S_IDLE, 1'b1, 1'b0, ropc());
   endtask

   task automatic test_rtype();
      run_instr("rtype", OP_R, 0, 0, 1'b0);
   endtask

   task automatic test_lw_wait();
      run_instr("lw_wait", OP_LW, 0, 2, 1'b0);
      run_instr("lw_nowait", OP_LW, 1, 0, 1'b0);
   endtask

   task automatic test_branch();
      run_instr("beq_taken", OP_BEQ, 0, 0, 1'b1);
      run_instr("bne_not_taken", OP_BNE, 0, 0, 1'b1);
      run_instr("beq_not_taken", OP_BEQ, 0, 0, 1'b0);
      run_instr("bne_taken", OP_BNE, 0, 0, 1'b0);
   endtask

   task automatic test_imm();
      run_instr("ori", OP_ORI, 0, 0, 1'b0);
      run_instr("lui", OP_LUI, 0, 0, 1'b0);
      run_instr("addi", OP_ADDI, 0, 0, 1'b0);
      run_instr("andi", OP_ANDI, 0, 0, 1'b0);
   endtask

   task automatic test_jump_sw();
      run_instr("jump", OP_J, 2, 0, 1'b0);
      run_instr("sw_wait", OP_SW, 0, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[10] = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
      for (int i = 0; i < 12; i++)
         run_instr("b2b", ops[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 2), rbit());
   endtask

   task automatic test_halt();
      run_instr("halt", 6'b111111, 0, 0, 1'b0);
      for (int i = 0; i < 9; i++) step("halt_hold", S_HALT, rbit(), rbit(), ropc());
      assert_reset("reset_in_halt");
      step("idle_after_halt", S_IDLE, 1'b0, 1'b0, ropc());
   endtask

   task automatic test_sw_reset();
      run_instr("fill_r", OP_R, 0, 0, 1'b0);
      step("sw_reset", S_FETCH, 1'b1, 1'b0, ropc());
      step("sw_reset", S_DECODE, 1'b1, 1'b0, OP_SW);
      step("sw_reset", S_MEM_ADDR, 1'b1, 1'b0, ropc());
      step("sw_reset", S_MEM_WRITE, 1'b0, 1'b0, ropc());
      step("sw_reset", S_MEM_WRITE, 1'b0, 1'b0, ropc());
      assert_reset("reset_in_mem_write");
      step("idle_after_sw", S_IDLE, 1'b0, 1'b0, ropc());
   endtask

`ifdef MULTICYCLE_PERF_CNT_EN
   task automatic test_perf();
      assert_reset("perf_reset");
      step("perf_idle", S_IDLE, 1'b0, 1'b0, ropc());
      for (int i = 0; i < 3; i++) run_instr("perf_r", OP_R, 0, 0, 1'b0);
      tests++;
      if (instr_count_o !== 32'd3) begin
         fails++;
         $display("FAIL perf_instr: got %0d expected 3", instr_count_o);
      end
      tests++;
      if (cycle_count_o !== 32'd12) begin
         fails++;
         $display("FAIL perf_cycle: got %0d expected 12", cycle_count_o);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; opcode_i = 6'd0; zero_i = 1'b0; mem_ready_i = 1'b0; cap_opc = 6'd0;
      @(negedge clk);
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branch();
      test_imm();
      test_jump_sw();
      test_back_to_back();
      test_halt();
      test_sw_reset();
`ifdef MULTICYCLE_PERF_CNT_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS core. Decodes the 6-bit opcode and sequences the shared ALU, the unified instruction/data memory, the PC and the register file across fetch, decode, execute, memory and write-back steps. It drives `alu_op_o` to the ALU control decoder, so a single ALU computes PC+4, branch targets, effective addresses and results. Memory accesses stall on a ready handshake.

## Interface
- `CNT_WIDTH`, 32: width of the performance counters (only used with the macro enabled).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode_i` in 6: instruction[31:26] from the instruction register.
- `zero_i` in 1: ALU zero flag.
- `mem_ready_i` in 1: memory has completed the current read or write this cycle.
- `pc_write_o` out 1: load the PC.
- `ir_write_o` out 1: load the instruction register.
- `mem_read_o` / `mem_write_o` out 1: memory strobes.
- `i_or_d_o` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `reg_write_o`, `reg_dst_o` (1 = rd, 0 = rt), `mem_to_reg_o` out 1: register file write controls.
- `alu_src_a_o` out 1: ALU A select, 0 = PC, 1 = rs.
- `alu_src_b_o` out 2: ALU B select, 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op_o` out 3: ALU operation class.
  - 111 = R-type (function field)
  - 100 = addi
  - 001 = lui
  - 010 = ori
  - 011 = andi
  - 101 = add (lw/sw/PC arithmetic)
  - 110 = branch compare (subtract)
- `pc_src_o` out 2: next-PC select, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `halted_o` out 1: an unsupported opcode was decoded.
- `state_o` out 4: current state encoding, for debug.

## Operation
- Moore FSM. Outputs are decoded from state only, except the `pc_write_o`/`ir_write_o` gating noted below. Outputs not listed for a state are 0, and `alu_op_o` defaults to 101.
- Supported opcodes: R 000000, j 000010, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, lui 001111, lw 100011, sw 101011.
- The opcode is captured into an internal register in DECODE. All later states use this captured value.
- States and transitions:
  - IDLE (0): all outputs 0. Go to FETCH unconditionally.
  - FETCH (1): `mem_read`=1, `i_or_d`=0, src_a=0, src_b=01, alu_op=101, pc_src=00.
    - `ir_write_o` and `pc_write_o` equal `mem_ready_i`.
    - Stay while `mem_ready_i`=0; go to DECODE when it is 1.
  - DECODE (2): src_a=0, src_b=11, alu_op=101 (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEM_ADDR
    - R → EXECUTE
    - beq/bne → BRANCH
    - j → JUMP
    - addi/andi/ori/lui → IMM_EXEC
    - any other opcode → HALT
  - MEM_ADDR (3): src_a=1, src_b=10, alu_op=101. Go to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ (4): `mem_read`=1, `i_or_d`=1. Wait for `mem_ready_i`, then go to MEM_WB.
  - MEM_WB (5): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Go to FETCH.
  - MEM_WRITE (6): `mem_write`=1, `i_or_d`=1. Wait for `mem_ready_i`, then go to FETCH.
  - EXECUTE (7): src_a=1, src_b=00, alu_op=111. Go to ALU_WB.
  - ALU_WB (8): `reg_write`=1, `reg_dst`=1. Go to FETCH.
  - BRANCH (9): src_a=1, src_b=00, alu_op=110, pc_src=01.
    - `pc_write_o` = (beq & `zero_i`) | (bne & !`zero_i`).
    - Go to FETCH.
  - IMM_EXEC (10): src_a=1, src_b=10, alu_op = 100/011/010/001 for addi/andi/ori/lui. Go to IMM_WB.
  - IMM_WB (11): `reg_write`=1, `reg_dst`=0. Go to FETCH.
  - JUMP (12): pc_src=10, `pc_write`=1. Go to FETCH.
  - HALT (13): `halted_o`=1, all other outputs 0. Stays until reset.
- Encodings 14–15 are unreachable. If entered, the next state is IDLE.

## Timing
- Reset (asynchronous assert): state becomes IDLE immediately and every output goes to 0, including `state_o`=0.
- Reset mid-access: `mem_read_o`/`mem_write_o` drop in the same cycle.
- First FETCH is in the second cycle after reset release.
- Cycle counts with zero memory wait: R/addi/andi/ori/lui 4, lw 5, sw 4, beq/bne 3, j 3. Each cycle `mem_ready_i` stays low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- `mem_ready_i` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- `zero_i` is sampled combinationally in BRANCH only.

## Configuration
- `MULTICYCLE_PERF_CNT_EN` defined adds two outputs, both reset to 0 and wrapping modulo 2^`CNT_WIDTH`:
  - `cycle_count_o` [CNT_WIDTH-1:0]: increments every cycle the state is neither IDLE nor HALT.
  - `instr_count_o` [CNT_WIDTH-1:0]: increments on every transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, IMM_WB or JUMP.
- Macro not defined: both ports and counters are absent. FSM behaviour is identical.

## Test plan
- Reset, then opcode 000000 with `mem_ready_i`=1 → `state_o` 0,1,2,7,8,1; `alu_op_o`=111 in EXECUTE; `reg_write_o`=`reg_dst_o`=1 in ALU_WB.
- lw (100011) with `mem_ready_i` low for 2 cycles in MEM_READ → MEM_READ held 3 cycles with `i_or_d_o`=1, then MEM_WB with `mem_to_reg_o`=1.
- beq with `zero_i`=1 → `pc_write_o`=1, `pc_src_o`=01 in BRANCH. bne with `zero_i`=1 → `pc_write_o`=0.
- ori (001101) → `alu_op_o`=010 and `alu_src_b_o`=10 in IMM_EXEC. lui (001111) → `alu_op_o`=001.
- Opcode 111111 → HALT, `halted_o`=1 held for 10 cycles. Reset asserted during HALT → `state_o`=0.
- sw with reset asserted during MEM_WRITE → `mem_write_o`=0 immediately. With `MULTICYCLE_PERF_CNT_EN`, after 3 R-type instructions → `instr_count_o`=3 and `cycle_count_o`=12.
